systolic_result_drain: RTL
==========================

Name: systolic_result_drain

Overview:
- Consumer at the output end of the systolic multiplier: captures each finished N x N result matrix when the result-valid pulse fires.
- Streams the matrix out one element per beat over a valid/ready interface, in row-major order.
- Ping-pong buffer of two matrix slots: one matrix is captured while the previous one drains.
- Sits between the multiplier top and the downstream result sink or bus bridge.

Parameters:
N, 4, matrix dimension; rows and columns per result.
W, 16, result element width in bits.

Ports:
i_clk  input  1  clock
i_arst_n  input  1  asynchronous active-low reset
i_c  input  [N-1:0][N-1:0][W-1:0]  result matrix; i_c[r][c] is row r, column c
i_validResult  input  1  single-cycle pulse; i_c is valid in this cycle only
o_data  output  W  current element
o_row  output  $clog2(N)  row index of o_data
o_col  output  $clog2(N)  column index of o_data
o_last  output  1  high on the final element (row N-1, column N-1) of a matrix
o_valid  output  1  o_data, o_row, o_col and o_last are valid
i_ready  input  1  sink accepts the beat; transfer = o_valid && i_ready
o_pending  output  2  number of occupied slots (0..2)
o_overflow  output  1  sticky flag: a result was dropped
i_clearOverflow  input  1  clears o_overflow

Behaviour:
- Reset (i_arst_n low, asynchronous): both slots empty, head pointer 0, element index 0, o_valid 0, o_pending 0, o_overflow 0, o_data/o_row/o_col/o_last 0.
- Capture:
  - On a clock edge with i_validResult high and the pulse accepted, i_c is written to the tail slot. The tail pointer toggles and o_pending increments.
  - Acceptance condition: o_pending < 2, or o_pending == 2 and the head's last element transfers in the same cycle.
- Drain:
  - o_valid is high whenever o_pending > 0.
  - Minimum latency: i_validResult in cycle t gives o_valid high at t+1 with element (0,0).
  - The element index runs row-major: (0,0), (0,1), ..., (0,N-1), (1,0), ..., (N-1,N-1). It advances only on a transfer.
  - While o_valid && !i_ready, all outputs hold stable.
- Matrix end:
  - On transfer of the element with o_last high, the head slot is freed, the head pointer toggles, the index resets to 0 and o_pending decrements.
  - If the other slot is full, its (0,0) element is presented in the next cycle (no bubble).
- Simultaneous capture and last transfer: o_pending stays unchanged in net.
  - A capture into the slot freed that cycle is legal only when o_pending == 2.
  - The freed head data is not overwritten until after its last beat is accepted. The write and the free occur on the same edge.
- Overflow:
  - i_validResult with o_pending == 2 and no last transfer: the matrix is dropped, slots are untouched, and o_overflow is set at the next edge.
  - o_overflow holds until the i_clearOverflow edge. If set and clear occur in the same cycle, set wins.
- i_c is sampled only in the cycle of an accepted i_validResult. It is a don't-care at all other times.
- All outputs are registered. There is no combinational path from i_ready or i_validResult to any output.
- Reset mid-drain discards all buffered data immediately. Post-reset behaviour is identical to power-up.

Test Plan:
- Single matrix, i_c[r][c] = 16'(r*4+c+1), i_ready held 1, pulse at cycle 0:
  - o_valid 1 for cycles 1..16 with o_data 1..16 in order.
  - o_last only in cycle 16; o_pending returns to 0 in cycle 17.
- Backpressure: same stimulus, i_ready = 1 on odd cycles only:
  - Each element is held stable until accepted.
  - 16 beats complete in order; o_row/o_col match each element.
- Back-to-back: two pulses 3 cycles apart (second matrix = first + 100), i_ready 1:
  - 32 contiguous beats, 1..16 then 101..116, with no bubble between them.
  - o_pending reaches 2.
- Overflow: i_ready 0, three pulses with distinct data:
  - o_pending = 2 and o_overflow = 1 after the third pulse.
  - Releasing i_ready drains only the first two matrices.
  - i_clearOverflow clears the flag; clear in the same cycle as a new drop leaves it set.
- Simultaneous free/capture: o_pending = 2, third pulse in the cycle the head's last beat transfers:
  - The pulse is accepted, o_overflow stays 0.
  - The remaining two matrices drain intact.
- Reset mid-drain: assert i_arst_n low during beat 7 of a matrix:
  - o_valid, o_pending and o_overflow go 0 asynchronously.
  - After release, a new pulse drains from (0,0) normally.

Source files
------------

// File: rtl/systolic_result_drain.sv
// Result drain for the systolic multiplier: ping-pong captures finished N x N
// matrices and streams them row-major over a registered valid/ready interface.
module systolic_result_drain #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic                         i_clk,
  input  logic                         i_arst_n,
  input  logic [N-1:0][N-1:0][W-1:0]   i_c,
  input  logic                         i_validResult,
  output logic [W-1:0]                 o_data,
  output logic [$clog2(N)-1:0]         o_row,
  output logic [$clog2(N)-1:0]         o_col,
  output logic                         o_last,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [1:0]                   o_pending,
  output logic                         o_overflow,
  input  logic                         i_clearOverflow
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  logic [1:0][N-1:0][N-1:0][W-1:0] slot;
  logic                            head;
  logic                            tail;

  logic          xfer;
  logic          last_xfer;
  logic          accept;
  logic          drop;
  logic          head_n;
  logic [IW-1:0] row_n;
  logic [IW-1:0] col_n;
  logic [1:0]    pending_n;
  logic [W-1:0]  data_n;

  // Outputs are registered, so the next beat is looked up from next-state
  // head/index; a matrix captured this edge into the next head slot is read
  // straight from i_c, which gives the one-cycle capture-to-valid latency.
  always_comb begin
    xfer      = o_valid & i_ready;
    last_xfer = xfer & o_last;
    accept    = i_validResult & ((o_pending != 2'd2) | last_xfer);
    drop      = i_validResult & ~accept;
    head_n    = head ^ last_xfer;

    row_n = o_row;
    col_n = o_col;
    if (last_xfer) begin
      row_n = '0;
      col_n = '0;
    end else if (xfer) begin
      if (o_col == IDX_MAX) begin
        col_n = '0;
        row_n = o_row + IW'(1);
      end else begin
        col_n = o_col + IW'(1);
      end
    end

    pending_n = o_pending;
    if (accept && !last_xfer)
      pending_n = o_pending + 2'd1;
    else if (!accept && last_xfer)
      pending_n = o_pending - 2'd1;

    if (pending_n == 2'd0)
      data_n = '0;
    else if (accept && (tail == head_n))
      data_n = i_c[row_n][col_n];
    else
      data_n = slot[head_n][row_n][col_n];
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      head       <= 1'b0;
      tail       <= 1'b0;
      o_pending  <= '0;
      o_valid    <= 1'b0;
      o_row      <= '0;
      o_col      <= '0;
      o_data     <= '0;
      o_last     <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      head       <= head_n;
      if (accept)
        tail <= ~tail;
      o_pending  <= pending_n;
      o_valid    <= (pending_n != 2'd0);
      o_row      <= row_n;
      o_col      <= col_n;
      o_data     <= data_n;
      o_last     <= (pending_n != 2'd0) && (row_n == IDX_MAX) && (col_n == IDX_MAX);
      o_overflow <= drop | (o_overflow & ~i_clearOverflow);
    end
  end

  // Slot storage needs no reset: occupancy is tracked by o_pending alone.
  always_ff @(posedge i_clk) begin
    if (accept)
      slot[tail] <= i_c;
  end

endmodule
